// File: rtl/rv32_writeback_if.sv
// ALU result / load response bundle into writeback.
// master: ALU+LSU side drives results; slave: writeback returns alu_ready.
interface rv32_writeback_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [2:0]      lsu_funct3;
    logic [1:0]      lsu_byte_offset;
    logic [XLEN-1:0] lsu_rdata;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output lsu_valid, lsu_rd, lsu_funct3,
        output lsu_byte_offset, lsu_rdata,
        input  alu_ready
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  lsu_valid, lsu_rd, lsu_funct3,
        input  lsu_byte_offset, lsu_rdata,
        output alu_ready
    );
endinterface

// File: rtl/rv32_writeback.sv
// RV32 writeback: merges ALU/load results into one registered RF write,
// extracts loads, and tracks outstanding loads for load-use detection.
// Ports: clk, reset_n (async, active low); wb (slave bundle: ALU result
// and load response); lsu_issue_valid/lsu_issue_rd (load issue);
// rs1/rs2_address -> rs1/rs2_busy; rd_address/rd_value (RF write);
// lsu_err (bad funct3 pulse).
// Option RV32_WB_BYPASS_EN adds rsN_fwd_hit/rsN_fwd_value forwarding.
module rv32_writeback #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    rv32_writeback_if.slave wb,
    input  logic            lsu_issue_valid,
    input  logic [4:0]      lsu_issue_rd,
    input  logic [4:0]      rs1_address,
    input  logic [4:0]      rs2_address,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [4:0]      rd_address,
    output logic [XLEN-1:0] rd_value,
    output logic            lsu_err
`ifdef RV32_WB_BYPASS_EN
    ,
    output logic            rs1_fwd_hit,
    output logic            rs2_fwd_hit,
    output logic [XLEN-1:0] rs1_fwd_value,
    output logic [XLEN-1:0] rs2_fwd_value
`endif
);

    logic [4:0]      rd_address_q, rd_address_d;
    logic [XLEN-1:0] rd_value_q, rd_value_d;
    logic            lsu_err_q, lsu_err_d;
    logic [31:0]     busy_q, busy_d;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_val;
    logic            load_ok;

    // Loads cannot be stalled, so they always win the write port.
    assign wb.alu_ready = ~wb.lsu_valid;

    always_comb begin
        byte_sel = wb.lsu_rdata[7:0];
        unique case (wb.lsu_byte_offset)
            2'd0: byte_sel = wb.lsu_rdata[7:0];
            2'd1: byte_sel = wb.lsu_rdata[15:8];
            2'd2: byte_sel = wb.lsu_rdata[23:16];
            2'd3: byte_sel = wb.lsu_rdata[31:24];
        endcase
    end

    // Halfword offset[0] is ignored; misalignment is the LSU's problem.
    assign half_sel = wb.lsu_byte_offset[1] ? wb.lsu_rdata[31:16]
                                            : wb.lsu_rdata[15:0];

    always_comb begin
        load_val = '0;
        load_ok  = 1'b1;
        case (wb.lsu_funct3)
            3'b000: load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001: load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010: load_val = wb.lsu_rdata;
            3'b100: load_val = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101: load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_address_d = 5'd0;
        rd_value_d   = rd_value_q;
        lsu_err_d    = 1'b0;
        if (wb.lsu_valid) begin
            if (load_ok) begin
                rd_address_d = wb.lsu_rd;
                rd_value_d   = load_val;
            end else begin
                lsu_err_d = 1'b1;
            end
        end else if (wb.alu_valid) begin
            rd_address_d = wb.alu_rd;
            rd_value_d   = wb.alu_result;
        end
    end

    // Set after clear: a same-cycle reissue keeps the register outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wb.lsu_valid) begin
            busy_d[wb.lsu_rd] = 1'b0;
        end
        if (lsu_issue_valid && (lsu_issue_rd != 5'd0)) begin
            busy_d[lsu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_address_q <= 5'd0;
            rd_value_q   <= '0;
            lsu_err_q    <= 1'b0;
            busy_q       <= '0;
        end else begin
            rd_address_q <= rd_address_d;
            rd_value_q   <= rd_value_d;
            lsu_err_q    <= lsu_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_address = rd_address_q;
    assign rd_value   = rd_value_q;
    assign lsu_err    = lsu_err_q;
    assign rs1_busy   = busy_q[rs1_address];
    assign rs2_busy   = busy_q[rs2_address];

`ifdef RV32_WB_BYPASS_EN
    // Covers the RF write-then-read window in the output cycle.
    assign rs1_fwd_hit   = (rs1_address == rd_address_q) &&
                           (rd_address_q != 5'd0);
    assign rs2_fwd_hit   = (rs2_address == rd_address_q) &&
                           (rd_address_q != 5'd0);
    assign rs1_fwd_value = rd_value_q;
    assign rs2_fwd_value = rd_value_q;
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// Self-checking bench for rv32_writeback: vector table, hand sequences
// for collision/scoreboard/reset, and a queue of expected RF writes.
`timescale 1ns/1ps
module tb_rv32_writeback;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ares;
        logic        lv;
        logic [4:0]  lrd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  erd;
        logic [31:0] eval;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        lsu_issue_valid;
    logic [4:0]  lsu_issue_rd;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  rd_address;
    logic [31:0] rd_value;
    logic        lsu_err;
`ifdef RV32_WB_BYPASS_EN
    logic        rs1_fwd_hit;
    logic        rs2_fwd_hit;
    logic [31:0] rs1_fwd_value;
    logic [31:0] rs2_fwd_value;
`endif

    rv32_writeback_if wbif ();

    rv32_writeback dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wb              (wbif.slave),
        .lsu_issue_valid (lsu_issue_valid),
        .lsu_issue_rd    (lsu_issue_rd),
        .rs1_address     (rs1_address),
        .rs2_address     (rs2_address),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rd_address      (rd_address),
        .rd_value        (rd_value),
        .lsu_err         (lsu_err)
`ifdef RV32_WB_BYPASS_EN
        ,
        .rs1_fwd_hit     (rs1_fwd_hit),
        .rs2_fwd_hit     (rs2_fwd_hit),
        .rs1_fwd_value   (rs1_fwd_value),
        .rs2_fwd_value   (rs2_fwd_value)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit pend = 0;
    logic [31:0] hold = 0;
    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, want, $time);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0,
              1'b0, 5'd0, 5'd0, 32'd0, 1'b0};
        return v;
    endfunction

    function automatic vec_t alu(input logic [4:0] rd,
                                 input logic [31:0] res);
        vec_t v;
        v = idle();
        v.av = 1'b1; v.ard = rd; v.ares = res;
        v.erd = rd; v.eval = res;
        return v;
    endfunction

    function automatic vec_t ld(input logic [4:0] rd, input logic [2:0] f3,
                                input logic [1:0] off,
                                input logic [31:0] w,
                                input logic [31:0] ev, input logic err);
        vec_t v;
        v = idle();
        v.lv = 1'b1; v.lrd = rd; v.f3 = f3; v.off = off; v.rdata = w;
        v.erd = err ? 5'd0 : rd; v.eval = ev; v.eerr = err;
        return v;
    endfunction

    // Independent load model: shift the word down, then extend.
    function automatic logic [31:0] mdl(input logic [2:0] f3,
                                        input logic [1:0] off,
                                        input logic [31:0] w);
        logic [31:0] s;
        logic [31:0] h;
        s = w >> (8 * off);
        h = w >> (16 * off[1]);
        case (f3)
            3'd0: return {{24{s[7]}}, s[7:0]};
            3'd1: return {{16{h[15]}}, h[15:0]};
            3'd4: return {24'd0, s[7:0]};
            3'd5: return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        wbif.alu_valid       = v.av;
        wbif.alu_rd          = v.ard;
        wbif.alu_result      = v.ares;
        wbif.lsu_valid       = v.lv;
        wbif.lsu_rd          = v.lrd;
        wbif.lsu_funct3      = v.f3;
        wbif.lsu_byte_offset = v.off;
        wbif.lsu_rdata       = v.rdata;
        lsu_issue_valid      = v.iv;
        lsu_issue_rd         = v.ird;
        if (v.erd != 5'd0) hold = v.eval;
        e.rd = v.erd; e.val = hold; e.err = v.eerr;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            cur <= exp_q.pop_front();
            pend <= 1'b1;
        end else begin
            pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (pend && reset_n) begin
            chk("wb_rd", {27'd0, rd_address}, {27'd0, cur.rd});
            chk("wb_val", rd_value, cur.val);
            chk("wb_err", {31'd0, lsu_err}, {31'd0, cur.err});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [31:0] w;
        logic [2:0] f3;
        logic [1:0] off;

        tbl.push_back(alu(5'd4, 32'd546));
        tbl.push_back(idle());
        tbl.push_back(ld(5'd10, 3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 0));
        tbl.push_back(ld(5'd11, 3'b100, 2'd1, 32'h80FF7F01, 32'h0000007F, 0));
        tbl.push_back(ld(5'd12, 3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF, 0));
        tbl.push_back(ld(5'd13, 3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01, 0));
        tbl.push_back(ld(5'd14, 3'b000, 2'd0, 32'h80FF7F01, 32'h00000001, 0));
        tbl.push_back(ld(5'd15, 3'b100, 2'd3, 32'h80FF7F01, 32'h00000080, 0));
        tbl.push_back(ld(5'd16, 3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF, 0));
        tbl.push_back(ld(5'd17, 3'b101, 2'd1, 32'h80FF7F01, 32'h00007F01, 0));
        tbl.push_back(ld(5'd18, 3'b010, 2'd2, 32'h80FF7F01, 32'h80FF7F01, 0));
        tbl.push_back(ld(5'd19, 3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 0));
        tbl.push_back(ld(5'd20, 3'b011, 2'd0, 32'h80FF7F01, 32'd0, 1));
        tbl.push_back(idle());
        tbl.push_back(ld(5'd21, 3'b110, 2'd0, 32'h12345678, 32'd0, 1));
        tbl.push_back(ld(5'd22, 3'b111, 2'd1, 32'h12345678, 32'd0, 1));
        tbl.push_back(alu(5'd31, 32'hCAFEF00D));
        tbl.push_back(alu(5'd1, 32'h00000001));
        tbl.push_back(idle());

        reset_n = 1'b0;
        rs1_address = 5'd0;
        rs2_address = 5'd0;
        v = idle();
        wbif.alu_valid = 0; wbif.alu_rd = 0; wbif.alu_result = 0;
        wbif.lsu_valid = 0; wbif.lsu_rd = 0; wbif.lsu_funct3 = 0;
        wbif.lsu_byte_offset = 0; wbif.lsu_rdata = 0;
        lsu_issue_valid = 0; lsu_issue_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", {27'd0, rd_address}, 32'd0);
        chk("rst_val", rd_value, 32'd0);
        chk("rst_err", {31'd0, lsu_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            chk("alu_ready", {31'd0, wbif.alu_ready}, {31'd0, ~tbl[i].lv});
        end

        // Collision: load wins, ALU held and written the next cycle.
        @(posedge clk); #1;
        v = alu(5'd5, 32'h11);
        v.lv = 1'b1; v.lrd = 5'd6; v.f3 = 3'b010; v.rdata = 32'hDEADBEEF;
        v.erd = 5'd6; v.eval = 32'hDEADBEEF;
        drive(v);
        @(negedge clk);
        chk("coll_ready0", {31'd0, wbif.alu_ready}, 32'd0);
        @(posedge clk); #1;
        drive(alu(5'd5, 32'h11));
        @(negedge clk);
        chk("coll_ready1", {31'd0, wbif.alu_ready}, 32'd1);
        @(posedge clk); #1;
        drive(idle());

        // Scoreboard.
        @(posedge clk); #1;
        v = idle(); v.iv = 1'b1; v.ird = 5'd7;
        drive(v);
        rs1_address = 5'd7;
        @(negedge clk);
        chk("sb_nobypass", {31'd0, rs1_busy}, 32'd0);
        @(posedge clk); #1;
        v = ld(5'd7, 3'b010, 2'd0, 32'h00001234, 32'h00001234, 0);
        v.iv = 1'b1; v.ird = 5'd7;
        drive(v);
        @(negedge clk);
        chk("sb_set", {31'd0, rs1_busy}, 32'd1);
        @(posedge clk); #1;
        drive(ld(5'd7, 3'b010, 2'd0, 32'h00005678, 32'h00005678, 0));
        @(negedge clk);
        chk("sb_setwins", {31'd0, rs1_busy}, 32'd1);
        @(posedge clk); #1;
        v = idle(); v.iv = 1'b1; v.ird = 5'd0;
        drive(v);
        rs2_address = 5'd0;
        @(negedge clk);
        chk("sb_clear", {31'd0, rs1_busy}, 32'd0);
        @(posedge clk); #1;
        drive(idle());
        @(negedge clk);
        chk("sb_x0", {31'd0, rs2_busy}, 32'd0);
        @(posedge clk); #1;
        v = idle(); v.iv = 1'b1; v.ird = 5'd3;
        drive(v);
        @(posedge clk); #1;
        v = idle(); v.iv = 1'b1; v.ird = 5'd20;
        drive(v);
        rs2_address = 5'd3;
        @(negedge clk);
        chk("sb_rs2", {31'd0, rs2_busy}, 32'd1);

`ifdef RV32_WB_BYPASS_EN
        @(posedge clk); #1;
        drive(alu(5'd9, 32'd123));
        @(posedge clk); #1;
        drive(idle());
        rs1_address = 5'd9;
        @(negedge clk);
        chk("fwd_hit", {31'd0, rs1_fwd_hit}, 32'd1);
        chk("fwd_val", rs1_fwd_value, 32'd123);
        @(posedge clk); #1;
        drive(alu(5'd9, 32'd77));
        rs1_address = 5'd0;
        @(posedge clk); #1;
        drive(idle());
        @(negedge clk);
        chk("fwd_x0", {31'd0, rs1_fwd_hit}, 32'd0);
`endif

        // Mid-run reset drops the in-flight write and the busy bits.
        @(posedge clk); #1;
        drive(alu(5'd2, 32'h55));
        @(posedge clk); #1;
        drive(idle());
        @(negedge clk);
        #1;
        wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd8; wbif.alu_result = 32'h99;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_rd", {27'd0, rd_address}, 32'd0);
        chk("mrst_val", rd_value, 32'd0);
        chk("mrst_err", {31'd0, lsu_err}, 32'd0);
        for (int r = 0; r < 32; r++) begin
            rs1_address = r[4:0];
            #0.1;
            chk("mrst_busy", {31'd0, rs1_busy}, 32'd0);
        end
        @(negedge clk);
        #1;
        v = idle();
        wbif.alu_valid = 1'b0;
        reset_n = 1'b1;
        hold = 32'd0;
        @(posedge clk); #1;
        drive(idle());

        // Randomised single-source writes against the bench model.
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            w = $urandom;
            off = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            case ($urandom_range(0, 2))
                0: v = alu(5'($urandom_range(1, 31)), w);
                1: v = ld(5'($urandom_range(1, 31)), f3, off, w,
                          mdl(f3, off, w), 0);
                default: v = idle();
            endcase
            drive(v);
        end
        @(posedge clk); #1;
        drive(idle());

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32_writeback.md
# rv32_writeback

Writeback stage of the RV32 core. It sits directly upstream of the register file and drives its `rd_address`/`rd_value` write port. It merges ALU results and load responses into one registered write per cycle, and performs load byte/halfword extraction with sign/zero extension. It also keeps a pending-load scoreboard so decode can detect load-use hazards.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` input 1: core clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result present this cycle.
- `alu_ready` output 1: ALU result accepted this cycle (combinational).
- `alu_rd` input 5: ALU destination register.
- `alu_result` input 32: ALU result value.
- `lsu_valid` input 1: load response present; cannot be stalled.
- `lsu_rd` input 5: load destination register.
- `lsu_funct3` input 3: load type.
- `lsu_byte_offset` input 2: address[1:0] of the load.
- `lsu_rdata` input 32: raw aligned memory word.
- `lsu_issue_valid` input 1: load issued to memory this cycle.
- `lsu_issue_rd` input 5: destination of the issued load.
- `rs1_address` input 5: decode source 1 to check against the scoreboard.
- `rs2_address` input 5: decode source 2 to check against the scoreboard.
- `rs1_busy` output 1: rs1 has an outstanding load (combinational).
- `rs2_busy` output 1: rs2 has an outstanding load (combinational).
- `rd_address` output 5: register-file write address; 0 when idle.
- `rd_value` output 32: register-file write data.
- `lsu_err` output 1: one-cycle pulse for an unsupported load funct3.

## Operation
- Arbitration: a load has absolute priority.
  - `alu_ready = ~lsu_valid`.
  - When both sources are valid, the load is written and the ALU holds its inputs.
- Output register:
  - A selected write loads `rd_address`/`rd_value`.
  - With no selection, `rd_address` is loaded with 0 and `rd_value` holds its old value. The register file ignores x0, so this is a no-op write.
- Load extraction, by `lsu_funct3`:
  - 000 LB: byte at `lsu_byte_offset`, sign-extended.
  - 001 LH: halfword selected by offset[1], sign-extended; offset[0] is ignored.
  - 010 LW: full word.
  - 100 LBU: byte at `lsu_byte_offset`, zero-extended.
  - 101 LHU: halfword selected by offset[1], zero-extended.
- Unsupported funct3 (011, 110, 111):
  - `rd_address` is forced to 0 and `lsu_err` pulses high in the next cycle.
  - The scoreboard bit for `lsu_rd` is still cleared.
- Scoreboard: 32 busy bits; bit 0 is hardwired to 0.
  - Set: `lsu_issue_valid` with `lsu_issue_rd` != 0.
  - Clear: an accepted load response for `lsu_rd`.
  - Set and clear of the same register in the same cycle: set wins, because the new issue is outstanding.
  - `rsN_busy = busy[rsN_address]`, with no bypass from a same-cycle issue or clear.
- ALU writes do not touch the scoreboard.

## Timing
- Latency: an input accepted in cycle N appears on `rd_address`/`rd_value` in cycle N+1. The register file captures it at the end of N+1, so it is readable in N+2.
- Back-to-back writes are sustained at one per cycle.
- Reset, asynchronous:
  - `rd_address` = 0, `rd_value` = 0, `lsu_err` = 0.
  - All busy bits cleared.
  - Reset mid-operation drops any pending write and forgets outstanding loads; the LSU is reset by the same `reset_n`.
- The ALU must keep `alu_valid`, `alu_rd` and `alu_result` stable until `alu_ready` is high.
- A `lsu_valid` for a register whose busy bit is clear is still written; the clear is a no-op.

## Configuration
- `RV32_WB_BYPASS_EN` defined: adds outputs `rs1_fwd_hit`, `rs2_fwd_hit` (1 bit each) and `rs1_fwd_value`, `rs2_fwd_value` (32 bits each).
  - `rsN_fwd_hit` = (`rsN_address` == `rd_address`) && (`rd_address` != 0).
  - `rsN_fwd_value` = `rd_value`.
  - This covers the register file's same-cycle write-then-read window.
- `RV32_WB_BYPASS_EN` undefined: these ports and their logic are absent. Decode must wait one extra cycle after a write before reading the destination.

## Test plan
- Reset: assert `reset_n`=0 mid-run -> `rd_address`=0, `rd_value`=0, `rs1_busy`=0 for every `rs1_address`, `lsu_err`=0.
- ALU write: `alu_valid`=1, `alu_rd`=4, `alu_result`=546 for one cycle -> next cycle `rd_address`=4, `rd_value`=546; the cycle after, `rd_address`=0.
- Collision: `alu_valid` (rd=5, 0x11) and `lsu_valid` (rd=6, LW, 0xDEADBEEF) in the same cycle -> `alu_ready`=0. Writes are rd=6 value 0xDEADBEEF, then rd=5 value 0x11 in consecutive cycles.
- Extraction with `lsu_rdata`=0x80FF7F01:
  - LB offset 3 -> 0xFFFFFF80.
  - LBU offset 1 -> 0x0000007F.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
  - funct3 011 -> `rd_address`=0 and a one-cycle `lsu_err` pulse.
- Scoreboard:
  - Issue rd=7 -> `rs1_busy`=1 for `rs1_address`=7.
  - Response for rd=7 alongside a new issue to rd=7 -> stays busy.
  - Second response -> clears.
  - Issue to rd=0 -> `rs2_busy` stays 0.
- Bypass (with `RV32_WB_BYPASS_EN`): ALU write rd=9 value 123 with `rs1_address`=9 in the output cycle -> `rs1_fwd_hit`=1, `rs1_fwd_value`=123. With `rs1_address`=0 -> `rs1_fwd_hit`=0.
